// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package md_pkg;

  localparam int unsigned MD_ITER  = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_ITER);

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } md_state_e;

  function automatic logic md_is_signed(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Multiply/divide datapath: magnitude capture, one radix-2 step per cycle, final sign fix-up.
module md_datapath
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_div,
  input  logic             is_signed,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc holds the product for multiply, or {remainder, quotient/dividend} for divide.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, shifted, diff;
  logic             ge;

  always_comb begin
    mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    sum     = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                       : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    shifted = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd_q};
    ge      = (shifted >= {1'b0, opnd_q});

    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;

    if (load) begin
      div_d     = is_div;
      neg_res_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_d = is_signed && a[WIDTH-1];
      bzero_d   = (b == '0);
      if (is_div) begin
        acc_d  = {{WIDTH{1'b0}}, mag_a};
        opnd_d = mag_b;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, mag_b};
        opnd_d = mag_a;
      end
    end else if (step) begin
      if (div_q) begin
        acc_d = {(ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
    end
  end

  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    quo = acc_q[WIDTH-1:0];
    rem = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      // Divide by zero yields all-ones quotient regardless of sign; remainder falls out as a.
      res_lo = bzero_q ? '1 : (neg_res_q ? -quo : quo);
      res_hi = neg_rem_q ? -rem : rem;
    end else begin
      {res_hi, res_lo} = neg_res_q ? -acc_q : acc_q;
    end
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: control FSM, iteration counter, cancel, and the HI/LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MD_CNT_W-1:0] LastCnt = MD_CNT_W'(MD_ITER - 1);

  md_state_e            state_q, state_d;
  logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 load, step;
  logic [WIDTH-1:0]     res_hi, res_lo;

  md_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .a         (a),
    .b         (b),
    .is_div    (md_is_div(op)),
    .is_signed (md_is_signed(op)),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flush in the same cycle kills the issuing instruction.
        if (start && !cancel) begin
          case (op)
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              load    = 1'b1;
              cnt_d   = '0;
              state_d = StCalc;
            end
            default: ;
          endcase
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO, a monitor checks on each done pulse.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  md_unit #(
    .WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1, expected done=0");
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_hi"}, hi, mon_e.hi);
        check({mon_e.name, "_lo"}, lo, mon_e.lo);
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input int restart_at);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back('{eh, el, name});
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == restart_at) begin
        start = 1'b1; op = MD_DIVU; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_busy_cycles"}, cyc, 32'd33);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;

    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5", 0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2", 0);
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2", 0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0);
    run_op(MD_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, "divu_by0", 0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0", 0);
    // Second start at cycle 5 must be ignored; the MULTU result and latency stand.
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_restart", 5);

    // MTHI then MTLO back to back.
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    start = 1'b1; op = MD_MTLO; a = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    check("mtlo_busy", {31'b0, busy}, 32'h0);

    // MULT cancelled at cycle 10.
    start = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("cancel_busy_before", {31'b0, busy}, 32'h1);
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy_after", {31'b0, busy}, 32'h0);
    check("cancel_done", {31'b0, done}, 32'h0);
    check("cancel_hi", hi, 32'h1234_5678);
    check("cancel_lo", lo, 32'hCAFE_F00D);
    repeat (40) @(negedge clk);
    check("cancel_idle_later", {31'b0, busy}, 32'h0);

    // MULTU in flight, ignored start at 5, reset at 20.
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd4;
    @(negedge clk);
    for (int cyc = 1; cyc < 20; cyc++) begin
      start = (cyc == 5);
      op = (cyc == 5) ? MD_DIVU : MD_MULTU;
      @(negedge clk);
    end
    start = 1'b0;
    check("midop_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    run_op(MD_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, "multu_after_rst", 0);

    repeat (3) @(negedge clk);
    check("pending_expect", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
